// File: rtl/mdio_poll_arbiter.sv
// rtl/mdio_poll_arbiter.sv - shares one MDIO transceiver between host register accesses and a periodic PHY status poll
module mdio_poll_arbiter #(
  parameter int unsigned POLL_INTERVAL = 1875000,
  parameter logic [4:0]  POLL_REG      = 5'h01,
  parameter int unsigned LINK_BIT      = 2
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        host_rd,
  input  logic        host_wr,
  input  logic [4:0]  host_reg_addr,
  input  logic [15:0] host_wr_data,
  output logic        host_busy,
  output logic        host_done,
  output logic [15:0] host_rd_data,
  input  logic        poll_en,
  output logic [15:0] poll_data,
  output logic        poll_valid,
  output logic        link_up,
  output logic        link_change,
  output logic [4:0]  mdio_reg_addr,
  output logic [15:0] mdio_wr_data,
  output logic        mdio_reg_rd,
  output logic        mdio_reg_wr,
  input  logic        mdio_busy,
  input  logic [15:0] mdio_rd_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {HOST, POLL} owner_t;

  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [3:0]  LINK_IDX  = LINK_BIT[3:0];

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  logic [31:0] poll_cnt;
  logic        poll_pending;
  logic        host_op_wr;
  logic [4:0]  host_addr;
  logic [15:0] host_data;
  logic [1:0]  guard_cnt;
  logic        grant_host;

  // host_busy doubles as the latched host request; ties go to whoever was not granted last
  assign grant_host = host_busy && (!poll_pending || last_grant == POLL);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= POLL;
      last_grant    <= POLL;
      poll_cnt      <= '0;
      poll_pending  <= 1'b0;
      host_op_wr    <= 1'b0;
      host_addr     <= '0;
      host_data     <= '0;
      guard_cnt     <= '0;
      host_busy     <= 1'b0;
      host_done     <= 1'b0;
      host_rd_data  <= '0;
      poll_data     <= '0;
      poll_valid    <= 1'b0;
      link_up       <= 1'b0;
      link_change   <= 1'b0;
      mdio_reg_addr <= '0;
      mdio_wr_data  <= '0;
      mdio_reg_rd   <= 1'b0;
      mdio_reg_wr   <= 1'b0;
    end else begin
      host_done   <= 1'b0;
      poll_valid  <= 1'b0;
      link_change <= 1'b0;

      if ((host_rd || host_wr) && !host_busy) begin
        host_busy  <= 1'b1;
        host_op_wr <= host_wr;
        host_addr  <= host_reg_addr;
        host_data  <= host_wr_data;
      end

      case (state)
        IDLE: begin
          if (!mdio_busy && (host_busy || poll_pending)) begin
            state <= ISSUE;
            if (grant_host) begin
              owner         <= HOST;
              last_grant    <= HOST;
              mdio_reg_addr <= host_addr;
              mdio_wr_data  <= host_data;
              mdio_reg_wr   <= host_op_wr;
              mdio_reg_rd   <= !host_op_wr;
            end else begin
              owner         <= POLL;
              last_grant    <= POLL;
              mdio_reg_addr <= POLL_REG;
              mdio_wr_data  <= '0;
              mdio_reg_rd   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mdio_reg_rd <= 1'b0;
          mdio_reg_wr <= 1'b0;
          guard_cnt   <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // the transceiver may take a couple of cycles to raise busy after the strobe
          if (guard_cnt != 2'd2) begin
            guard_cnt <= guard_cnt + 2'd1;
          end else if (!mdio_busy) begin
            state <= IDLE;
            if (owner == HOST) begin
              host_done <= 1'b1;
              host_busy <= 1'b0;
              if (!host_op_wr) host_rd_data <= mdio_rd_data;
            end else begin
              poll_data    <= mdio_rd_data;
              poll_valid   <= 1'b1;
              poll_pending <= 1'b0;
              link_up      <= mdio_rd_data[LINK_IDX];
              link_change  <= (mdio_rd_data[LINK_IDX] != link_up);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // placed after completion so an expiry in the completing cycle is not lost
      if (!poll_en) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b0;
      end else if (poll_cnt == POLL_LAST) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_mdio_poll_arbiter.sv
// tb/tb_mdio_poll_arbiter.sv - self-checking bench with a register-file PHY model and transaction-level expectations
module tb_mdio_poll_arbiter;
  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_rd = 1'b0, host_wr = 1'b0;
  logic [4:0]  host_reg_addr = '0;
  logic [15:0] host_wr_data = '0;
  logic        host_busy, host_done;
  logic [15:0] host_rd_data;
  logic        poll_en = 1'b0;
  logic [15:0] poll_data;
  logic        poll_valid, link_up, link_change;
  logic [4:0]  mdio_reg_addr;
  logic [15:0] mdio_wr_data;
  logic        mdio_reg_rd, mdio_reg_wr;
  logic        mdio_busy;
  logic [15:0] mdio_rd_data = '0;

  logic        phy_hold = 1'b0;
  logic        phy_busy = 1'b0;
  int          phy_lat = 4;
  int          busy_left = 0;
  logic [15:0] phy_regs [32];
  logic [15:0] shadow [32];

  typedef struct {bit wr; logic [4:0] a; logic [15:0] d;} op_t;
  op_t op_q[$];

  int n_strobe = 0, n_overlap = 0, n_done = 0, n_pv = 0, n_lc = 0, cyc = 0;
  int n_cmp = 0, n_err = 0;

  assign mdio_busy = phy_hold | phy_busy;

  mdio_poll_arbiter #(.POLL_INTERVAL(100), .POLL_REG(5'h01), .LINK_BIT(2)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .host_rd(host_rd), .host_wr(host_wr), .host_reg_addr(host_reg_addr), .host_wr_data(host_wr_data),
    .host_busy(host_busy), .host_done(host_done), .host_rd_data(host_rd_data),
    .poll_en(poll_en), .poll_data(poll_data), .poll_valid(poll_valid),
    .link_up(link_up), .link_change(link_change),
    .mdio_reg_addr(mdio_reg_addr), .mdio_wr_data(mdio_wr_data),
    .mdio_reg_rd(mdio_reg_rd), .mdio_reg_wr(mdio_reg_wr),
    .mdio_busy(mdio_busy), .mdio_rd_data(mdio_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // transceiver: register file, busy for phy_lat cycles after each strobe
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (mdio_reg_rd && mdio_reg_wr) n_overlap++;
    if (mdio_reg_rd || mdio_reg_wr) begin
      n_strobe++;
      op_q.push_back(op_t'{mdio_reg_wr, mdio_reg_addr, mdio_wr_data});
      if (mdio_reg_wr) phy_regs[mdio_reg_addr] = mdio_wr_data;
      else mdio_rd_data = phy_regs[mdio_reg_addr];
      busy_left = phy_lat;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    phy_busy = (busy_left > 0);
    if (host_done) n_done++;
    if (poll_valid) n_pv++;
    if (link_change) n_lc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1; poll_en = 1'b0; host_rd = 1'b0; host_wr = 1'b0; phy_hold = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic host_op(input bit wr, input bit rd, input logic [4:0] a, input logic [15:0] d, input string tag);
    @(negedge sys_clk);
    host_wr = wr; host_rd = rd; host_reg_addr = a; host_wr_data = d;
    @(negedge sys_clk);
    host_wr = 1'b0; host_rd = 1'b0;
    chk({tag, "_busy_set"}, host_busy, 1);
  endtask

  task automatic wait_host_done(input string tag);
    bit seen = 0;
    bit busy_ok = 1;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge sys_clk);
      if (host_done) seen = 1;
      else if (!host_busy) busy_ok = 0;
    end
    chk({tag, "_done"}, seen, 1);
    chk({tag, "_busy_held"}, busy_ok, 1);
    if (seen) chk({tag, "_busy_fall"}, host_busy, 0);
  endtask

  task automatic wait_poll(input string tag, output int at);
    bit seen = 0;
    at = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge sys_clk);
      if (poll_valid) begin seen = 1; at = cyc; end
    end
    chk({tag, "_valid"}, seen, 1);
  endtask

  initial begin
    int s0, s1, d0, t1, t2, pv0, lc0;
    bit ok;
    logic [15:0] last_rd;

    for (int i = 0; i < 32; i++) begin
      shadow[i] = 16'($urandom);
      phy_regs[i] = shadow[i];
    end

    do_reset();
    chk("rst_host_busy", host_busy, 0);
    chk("rst_host_done", host_done, 0);
    chk("rst_host_rd_data", host_rd_data, 0);
    chk("rst_poll_data", poll_data, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_strobes", {mdio_reg_rd, mdio_reg_wr}, 0);
    chk("rst_mdio_addr", mdio_reg_addr, 0);

    // host read of reg 3 with a slow transceiver
    shadow[3] = 16'h1234; phy_regs[3] = 16'h1234; phy_lat = 20;
    op_q.delete(); s0 = n_strobe; d0 = n_done;
    host_op(0, 1, 5'd3, 16'h0, "rd3");
    wait_host_done("rd3");
    repeat (5) @(negedge sys_clk);
    chk("rd3_strobes", n_strobe - s0, 1);
    chk("rd3_op", (op_q.size() == 1 && !op_q[0].wr && op_q[0].a == 5'd3), 1);
    chk("rd3_data", host_rd_data, 16'h1234);
    chk("rd3_done_cnt", n_done - d0, 1);
    last_rd = 16'h1234;

    // random host traffic against the shadow register file; first op strobes rd and wr together
    for (int i = 0; i < 8; i++) begin
      bit wr, rd;
      logic [4:0] a;
      logic [15:0] d;
      a = 5'($urandom); d = 16'($urandom); phy_lat = $urandom_range(0, 12);
      if (i == 0) begin wr = 1; rd = 1; end
      else begin wr = 1'($urandom_range(0, 1)); rd = !wr; end
      op_q.delete();
      host_op(wr, rd, a, d, "rnd");
      wait_host_done("rnd");
      repeat (2) @(negedge sys_clk);
      chk("rnd_nops", op_q.size(), 1);
      if (op_q.size() == 1) begin
        chk("rnd_kind", op_q[0].wr, wr);
        chk("rnd_addr", op_q[0].a, a);
        if (wr) chk("rnd_wdata", op_q[0].d, d);
      end
      if (wr) shadow[a] = d;
      else last_rd = shadow[a];
      chk("rnd_rd_data", host_rd_data, last_rd);
    end

    // strobe while busy is ignored
    op_q.delete(); s0 = n_strobe; d0 = n_done; phy_lat = 10;
    host_op(0, 1, 5'd7, 16'h0, "ign");
    host_wr = 1'b1; host_reg_addr = 5'd9; host_wr_data = 16'hBEEF;
    @(negedge sys_clk);
    host_wr = 1'b0;
    wait_host_done("ign");
    repeat (30) @(negedge sys_clk);
    chk("ign_strobes", n_strobe - s0, 1);
    chk("ign_done_cnt", n_done - d0, 1);
    chk("ign_op", (op_q.size() == 1 && !op_q[0].wr && op_q[0].a == 5'd7), 1);
    chk("ign_rd_data", host_rd_data, shadow[7]);

    // autonomous polling and link status
    do_reset();
    phy_regs[1] = 16'h7809; phy_lat = 5; op_q.delete(); lc0 = n_lc;
    poll_en = 1'b1;
    wait_poll("poll1", t1);
    chk("poll1_data", poll_data, 16'h7809);
    chk("poll1_link", link_up, 0);
    chk("poll1_change", link_change, 0);
    phy_regs[1] = 16'h780D;
    wait_poll("poll2", t2);
    chk("poll_spacing", t2 - t1, 100);
    chk("poll2_data", poll_data, 16'h780D);
    chk("poll2_link", link_up, 1);
    chk("poll2_change", link_change, 1);
    @(negedge sys_clk);
    chk("poll_valid_pulse", poll_valid, 0);
    poll_en = 1'b0;
    chk("poll_change_cnt", n_lc - lc0, 1);
    ok = 1;
    foreach (op_q[i]) if (op_q[i].wr || op_q[i].a != 5'h01) ok = 0;
    chk("poll_ops_read_bmsr", ok, 1);

    // contention: host and poll both pending when the transceiver frees up
    do_reset();
    op_q.delete(); phy_lat = 3;
    for (int r = 0; r < 4; r++) begin
      logic [4:0] a;
      logic [15:0] d;
      a = 5'($urandom_range(2, 31)); d = 16'($urandom);
      phy_hold = 1'b1; poll_en = 1'b1;
      host_op(1, 0, a, d, "cont");
      shadow[a] = d;
      repeat (110) @(negedge sys_clk);
      phy_hold = 1'b0;
      repeat (25) @(negedge sys_clk);
      poll_en = 1'b0;
      repeat (10) @(negedge sys_clk);
    end
    chk("cont_nops", op_q.size(), 8);
    ok = 1;
    foreach (op_q[i]) begin
      if (op_q[i].wr != (i % 2 == 0)) ok = 0;
      if ((i % 2 == 1) && op_q[i].a != 5'h01) ok = 0;
    end
    chk("cont_alternate", ok, 1);

    // reset while waiting on a slow read
    phy_lat = 40; poll_en = 1'b0;
    s0 = n_strobe;
    host_op(0, 1, 5'd5, 16'h0, "rstw");
    for (int n = 0; n < 100 && n_strobe == s0; n++) @(negedge sys_clk);
    chk("rstw_strobe", n_strobe - s0, 1);
    repeat (5) @(negedge sys_clk);
    d0 = n_done;
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    chk("rstw_host_busy", host_busy, 0);
    chk("rstw_host_rd_data", host_rd_data, 0);
    chk("rstw_outs", {host_done, poll_valid, link_up, link_change, mdio_reg_rd, mdio_reg_wr}, 0);
    chk("rstw_mdio_addr", mdio_reg_addr, 0);
    chk("rstw_phy_still_busy", mdio_busy, 1);
    s0 = n_strobe;
    host_op(0, 1, 5'd6, 16'h0, "rstw2");
    for (int n = 0; n < 100 && mdio_busy; n++) @(negedge sys_clk);
    chk("rstw_busy_fell", mdio_busy, 0);
    chk("rstw_no_strobe_while_busy", n_strobe - s0, 0);
    wait_host_done("rstw2");
    chk("rstw_done_cnt", n_done - d0, 1);
    chk("rstw_rd_data", host_rd_data, shadow[6]);

    // poll_en dropped while a poll is in flight
    do_reset();
    phy_lat = 30; s0 = n_strobe;
    poll_en = 1'b1;
    for (int n = 0; n < 300 && n_strobe == s0; n++) @(negedge sys_clk);
    chk("drop_strobe", n_strobe - s0, 1);
    repeat (3) @(negedge sys_clk);
    poll_en = 1'b0;
    pv0 = n_pv;
    wait_poll("drop", t1);
    s1 = n_strobe;
    repeat (300) @(negedge sys_clk);
    chk("drop_no_more_polls", n_strobe - s1, 0);
    chk("drop_pv_cnt", n_pv - pv0, 1);

    chk("no_strobe_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
